elevator_scan_ctrl: RTL



---
 rtl/elevator_pkg.sv | 28 ++
 rtl/elevator_req_scan.sv | 27 ++
 rtl/elevator_scan_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// Floor one-hot helper is sized for the largest supported building.
package elevator_pkg;

   localparam int MAX_FLOORS = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MOVE_UP   = 2'd1,
      ST_MOVE_DOWN = 2'd2,
      ST_DOOR_OPEN = 2'd3
   } state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   function automatic logic [MAX_FLOORS-1:0] floor_onehot(input int floor, input int n);
      logic [MAX_FLOORS-1:0] oh;
      oh = '0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         oh[i] = (i == floor) && (i < n);
      end
      return oh;
   endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: is anything pending above, below or at a floor.
// Kept standalone so a multi-car dispatcher can reuse it per car.
module elevator_req_scan
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 6,
   parameter int FLOOR_W    = 4
) (
   input  logic [NUM_FLOORS-1:0] i_pending,
   input  logic [FLOOR_W-1:0]    i_floor,
   output logic                  o_above,
   output logic                  o_below,
   output logic                  o_here
);

   always_comb begin
      o_above = 1'b0;
      o_below = 1'b0;
      o_here  = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(i_floor))  o_above = o_above | i_pending[i];
         if (i < int'(i_floor))  o_below = o_below | i_pending[i];
         if (i == int'(i_floor)) o_here  = o_here  | i_pending[i];
      end
   end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: latched calls, shared travel/door timer,
// direction kept while requests remain ahead.
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = 6,
   parameter int FLOOR_W      = 4,
   parameter int TRAVEL_TICKS = 100000,
   parameter int DOOR_TICKS   = 200000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_req,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic                  idle,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
   localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   state_t                r_state, w_state_nxt, w_dec_state;
   dir_t                  r_last_dir, w_dir_nxt, w_dec_dir;
   logic [FLOOR_W-1:0]    r_floor, w_floor_nxt, w_eval_floor;
   logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt, w_eval_oh, w_clear_mask;
   logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
   logic                  w_travel_done, w_door_done, w_call_here;
   logic                  w_above, w_below, w_here;

   assign w_travel_done = (r_timer == TIMER_W'(TRAVEL_TICKS - 1));
   assign w_door_done   = (r_timer == TIMER_W'(DOOR_TICKS - 1));

   // Decisions on the arrival edge must see the floor we are about to occupy.
   always_comb begin
      w_eval_floor = r_floor;
      if (r_state == ST_MOVE_UP && w_travel_done)   w_eval_floor = r_floor + FLOOR_W'(1);
      if (r_state == ST_MOVE_DOWN && w_travel_done) w_eval_floor = r_floor - FLOOR_W'(1);
   end

   assign w_eval_oh = NUM_FLOORS'(floor_onehot(int'(w_eval_floor), NUM_FLOORS));

   elevator_req_scan #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_req_scan (
      .i_pending (r_pending),
      .i_floor   (w_eval_floor),
      .o_above   (w_above),
      .o_below   (w_below),
      .o_here    (w_here)
   );

   always_comb begin
      w_dec_state = ST_IDLE;
      w_dec_dir   = r_last_dir;
      if (w_here) begin
         w_dec_state = ST_DOOR_OPEN;
      end else if (w_above && (r_last_dir == DIR_UP || !w_below)) begin
         w_dec_state = ST_MOVE_UP;
         w_dec_dir   = DIR_UP;
      end else if (w_below) begin
         w_dec_state = ST_MOVE_DOWN;
         w_dec_dir   = DIR_DOWN;
      end
   end

   assign w_call_here = (r_state == ST_DOOR_OPEN) && ((call_req & w_eval_oh) != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_last_dir;
      w_floor_nxt = r_floor;
      w_timer_nxt = r_timer + TIMER_W'(1);
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = w_dec_state;
            w_dir_nxt   = w_dec_dir;
            w_timer_nxt = '0;
         end
         ST_MOVE_UP, ST_MOVE_DOWN: begin
            if (w_travel_done) begin
               w_floor_nxt = w_eval_floor;
               w_state_nxt = w_dec_state;
               w_dir_nxt   = w_dec_dir;
               w_timer_nxt = '0;
            end
         end
         ST_DOOR_OPEN: begin
            // A repeat call at this floor restarts the dwell instead of latching.
            if (w_call_here) begin
               w_timer_nxt = '0;
            end else if (w_door_done) begin
               w_state_nxt = w_dec_state;
               w_dir_nxt   = w_dec_dir;
               w_timer_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   assign w_clear_mask  = (w_state_nxt == ST_DOOR_OPEN) ? w_eval_oh : '0;
   assign w_pending_nxt = (r_pending | call_req) & ~w_clear_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_last_dir <= DIR_UP;
         r_floor    <= '0;
         r_pending  <= '0;
         r_timer    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_last_dir <= w_dir_nxt;
         r_floor    <= w_floor_nxt;
         r_pending  <= w_pending_nxt;
         r_timer    <= w_timer_nxt;
      end
   end

   assign current_floor = r_floor;
   assign pending       = r_pending;
   assign idle          = (r_state == ST_IDLE);
   assign moving_up     = (r_state == ST_MOVE_UP);
   assign moving_down   = (r_state == ST_MOVE_DOWN);
   assign door_open     = (r_state == ST_DOOR_OPEN);

   a_no_up_at_top: assert property (@(posedge clk) disable iff (!rst_n)
      !(r_state == ST_MOVE_UP && r_floor == FLOOR_W'(NUM_FLOORS - 1)));
   a_no_down_at_bottom: assert property (@(posedge clk) disable iff (!rst_n)
      !(r_state == ST_MOVE_DOWN && r_floor == '0));

endmodule
